instruction_dispatch: RTL and testbench

- Sequencer directly upstream of the execute units (load, store, compute).
- Holds a host-written program of wide instruction words; runs it num_iterations times.
- Per instruction: fetch, decode opcode, drive the register file, pulse op_start to one unit, wait for that unit's op_done.
- Flags completion to the control/CSR logic.

---
 rtl/glm_common.sv | 33 +++
 rtl/instruction_ram.sv | 37 +++
 rtl/instruction_dispatch.sv | 241 ++++++++++++++++++++++++
 tb/tb_instruction_dispatch.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glm_common.sv
// -----------------------------------------------------------------------------
// glm_common
// Shared types for the instruction dispatch block and its instruction RAM.
//   NUM_REGS         : 32-bit registers carried by one instruction word
//   t_opcode         : execute-unit opcodes (low nibble of register 0)
//   t_instruction    : one instruction word; register k is bits [32k+31:32k]
//   t_dispatch_state : dispatch sequencer states
// -----------------------------------------------------------------------------
package glm_common;

   localparam int NUM_REGS = 4;

   typedef enum logic [3:0] {
      LOAD   = 4'd0,
      STORE  = 4'd1,
      DOT    = 4'd2,
      MODIFY = 4'd3
   } t_opcode;

   typedef struct packed {
      logic [NUM_REGS-1:0][31:0] regs;
   } t_instruction;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      DECODE    = 3'd2,
      WAIT_DONE = 3'd3,
      NEXT      = 3'd4,
      FINISH    = 3'd5
   } t_dispatch_state;

endpackage

// File: rtl/instruction_ram.sv
// -----------------------------------------------------------------------------
// instruction_ram
// Host-written program store: one write port, one read port, registered read.
// A read of the address being written in the same cycle returns the old word.
//   i_clk    : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address, sampled every cycle
//   o_rdata  : word at i_raddr from the previous cycle
// -----------------------------------------------------------------------------
module instruction_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = 8,
   parameter int W     = 128
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [DEPTH];
   logic [W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/instruction_dispatch.sv
// -----------------------------------------------------------------------------
// instruction_dispatch
// Sequencer in front of the execute units. Runs a host-written program
// num_iterations times: fetch a word, decode its opcode, present the word on
// regs, pulse op_start for that unit, wait for the unit's op_done.
//
// Optional feature macro: GLM_DISPATCH_TIMEOUT_EN adds the timeout_err output
// and a WAIT_DONE watchdog of TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : one-cycle run request, ignored while busy
//   program_length      : instruction count, latched at start
//   num_iterations      : passes over the program, latched at start
//   instr_we/waddr/wdata: instruction RAM write port
//   regs                : registers of the most recently dispatched word
//   op_start            : one-hot, one-cycle unit start
//   op_done             : one-cycle unit completion pulses
//   busy, done          : run in progress / one-cycle end-of-program pulse
//   pc, iteration       : current instruction index / completed passes
//   illegal_count       : skipped illegal opcodes (saturating)
//   timeout_err         : watchdog expired (only with the macro)
//   dbg_state           : current sequencer state
//
// Handshake: op_start[u] is a single-cycle request; the unit answers later with
// a single-cycle op_done[u]. Only op_done of the unit that was started, seen
// after the op_start cycle while in WAIT_DONE, is accepted; all others drop.
// -----------------------------------------------------------------------------
module instruction_dispatch
   import glm_common::*;
#(
   parameter int NUM_UNITS      = 4,
   parameter int PROG_SIZE      = 256,
   parameter int LOG2_PROG_SIZE = 8
`ifdef GLM_DISPATCH_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 2**24
`endif
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [15:0]               program_length,
   input  logic [31:0]               num_iterations,
   input  logic                      instr_we,
   input  logic [LOG2_PROG_SIZE-1:0] instr_waddr,
   input  logic [32*NUM_REGS-1:0]    instr_wdata,
   output logic [31:0]               regs [NUM_REGS],
   output logic [NUM_UNITS-1:0]      op_start,
   input  logic [NUM_UNITS-1:0]      op_done,
   output logic                      busy,
   output logic                      done,
   output logic [LOG2_PROG_SIZE-1:0] pc,
   output logic [31:0]               iteration,
   output logic [15:0]               illegal_count,
`ifdef GLM_DISPATCH_TIMEOUT_EN
   output logic                      timeout_err,
`endif
   output t_dispatch_state           dbg_state
);

   localparam int OPW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   t_dispatch_state        r_state;
   t_dispatch_state        w_state_next;

   logic [15:0]            r_len;
   logic [31:0]            r_num_iter;
   // Full-width instruction index so the end-of-pass compare works for
   // program lengths beyond PROG_SIZE; the RAM address is its low bits.
   logic [15:0]            r_pos;
   logic [31:0]            r_iter;
   logic [15:0]            r_illegal;
   t_instruction           r_instr;
   logic [OPW-1:0]         r_opcode;
   logic [NUM_UNITS-1:0]   r_op_start;

   logic [32*NUM_REGS-1:0] w_rdata;
   t_instruction           w_word;
   t_opcode                w_opcode;
   logic                   w_legal;
   logic                   w_empty;
   logic                   w_last;
   logic [31:0]            w_iter_inc;
   logic                   w_unit_done;
   logic                   w_timeout;

   instruction_ram #(
      .DEPTH (PROG_SIZE),
      .AW    (LOG2_PROG_SIZE),
      .W     (32*NUM_REGS)
   ) u_ram (
      .i_clk   (clk),
      .i_we    (instr_we),
      .i_waddr (instr_waddr),
      .i_wdata (instr_wdata),
      .i_raddr (r_pos[LOG2_PROG_SIZE-1:0]),
      .o_rdata (w_rdata)
   );

   assign w_word      = t_instruction'(w_rdata);
   assign w_opcode    = t_opcode'(w_word.regs[0][3:0]);
   assign w_legal     = 32'(w_opcode) < NUM_UNITS;
   assign w_empty     = (r_len == 16'd0) || (r_num_iter == 32'd0);
   assign w_last      = (r_pos == r_len - 16'd1);
   assign w_iter_inc  = r_iter + 32'd1;
   // r_op_start is non-zero only in the first WAIT_DONE cycle; a done pulse
   // coincident with the start pulse is not an answer to it.
   assign w_unit_done = op_done[r_opcode] && (r_op_start == '0);

`ifdef GLM_DISPATCH_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_wait_cnt;
   logic          r_timeout_err;

   // Counter is 0 in the first WAIT_DONE cycle, so FINISH is entered exactly
   // TIMEOUT_CYCLES cycles after WAIT_DONE entry.
   assign w_timeout = (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wait_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (r_state == WAIT_DONE) begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
         end else begin
            r_wait_cnt <= '0;
         end
         if (r_state == IDLE && start) begin
            r_timeout_err <= 1'b0;
         end else if (r_state == WAIT_DONE && !w_unit_done && w_timeout) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign timeout_err = r_timeout_err;
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (start) w_state_next = FETCH;
         end
         // Zero length or zero iterations is resolved on the latched values
         // here, which puts done two cycles after start.
         FETCH: begin
            w_state_next = w_empty ? FINISH : DECODE;
         end
         DECODE: begin
            w_state_next = w_legal ? WAIT_DONE : NEXT;
         end
         WAIT_DONE: begin
            if (w_unit_done)    w_state_next = NEXT;
            else if (w_timeout) w_state_next = FINISH;
         end
         NEXT: begin
            if (w_last && (w_iter_inc == r_num_iter)) w_state_next = FINISH;
            else                                       w_state_next = FETCH;
         end
         FINISH: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_len      <= '0;
         r_num_iter <= '0;
         r_pos      <= '0;
         r_iter     <= '0;
         r_illegal  <= '0;
         r_instr    <= '0;
         r_opcode   <= '0;
         r_op_start <= '0;
      end else begin
         r_op_start <= '0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_len      <= program_length;
                  r_num_iter <= num_iterations;
                  r_pos      <= '0;
                  r_iter     <= '0;
                  r_illegal  <= '0;
               end
            end
            DECODE: begin
               if (w_legal) begin
                  r_instr    <= w_word;
                  r_opcode   <= OPW'(w_opcode);
                  r_op_start <= NUM_UNITS'(1) << OPW'(w_opcode);
               end else if (r_illegal != 16'hFFFF) begin
                  r_illegal <= r_illegal + 16'd1;
               end
            end
            NEXT: begin
               if (w_last) begin
                  r_pos  <= '0;
                  r_iter <= w_iter_inc;
               end else begin
                  r_pos <= r_pos + 16'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_REGS; k++) begin
         regs[k] = r_instr.regs[k];
      end
   end

   assign op_start      = r_op_start;
   assign busy          = (r_state != IDLE) && (r_state != FINISH);
   assign done          = (r_state == FINISH);
   assign pc            = r_pos[LOG2_PROG_SIZE-1:0];
   assign iteration     = r_iter;
   assign illegal_count = r_illegal;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_instruction_dispatch.sv
module tb_instruction_dispatch;
   import glm_common::*;

   localparam int NUM_UNITS = 4;
   localparam int AW        = 8;

   logic                   clk;
   logic                   reset;
   logic                   start;
   logic [15:0]            program_length;
   logic [31:0]            num_iterations;
   logic                   instr_we;
   logic [AW-1:0]          instr_waddr;
   logic [32*NUM_REGS-1:0] instr_wdata;
   logic [31:0]            regs [NUM_REGS];
   logic [NUM_UNITS-1:0]   op_start;
   logic [NUM_UNITS-1:0]   op_done;
   logic                   busy;
   logic                   done;
   logic [AW-1:0]          pc;
   logic [31:0]            iteration;
   logic [15:0]            illegal_count;
   t_dispatch_state        dbg_state;
`ifdef GLM_DISPATCH_TIMEOUT_EN
   logic                   timeout_err;
`endif

   instruction_dispatch #(
      .NUM_UNITS      (NUM_UNITS),
      .PROG_SIZE      (256),
      .LOG2_PROG_SIZE (AW)
`ifdef GLM_DISPATCH_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (100)
`endif
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .program_length (program_length),
      .num_iterations (num_iterations),
      .instr_we       (instr_we),
      .instr_waddr    (instr_waddr),
      .instr_wdata    (instr_wdata),
      .regs           (regs),
      .op_start       (op_start),
      .op_done        (op_done),
      .busy           (busy),
      .done           (done),
      .pc             (pc),
      .iteration      (iteration),
      .illegal_count  (illegal_count),
`ifdef GLM_DISPATCH_TIMEOUT_EN
      .timeout_err    (timeout_err),
`endif
      .dbg_state      (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int                   n_checks = 0;
   int                   n_pass   = 0;
   logic [NUM_UNITS-1:0] exp_q[$];
   int                   start_cyc_q[$];
   logic [NUM_UNITS-1:0] start_val_q[$];
   logic [127:0]         start_regs_q[$];
   int                   done_cnt;
   int                   done_cyc;
   logic                 done_busy;
   logic                 busy_c1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [127:0] pack_regs();
      logic [127:0] v;
      v = '0;
      for (int k = 0; k < NUM_REGS; k++) v[32*k +: 32] = regs[k];
      return v;
   endfunction

   // Word with opcode op in register 0 and a tag in every register.
   function automatic logic [127:0] mk(input logic [3:0] op, input logic [7:0] tag);
      return {8'hD3, 16'h0, tag, 8'hC2, 16'h0, tag, 8'hB1, 16'h0, tag,
              8'hA0, 12'h0, tag, op};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic write_word(input int addr, input logic [127:0] w);
      @(negedge clk);
      instr_we    = 1'b1;
      instr_waddr = AW'(addr);
      instr_wdata = w;
      @(negedge clk);
      instr_we    = 1'b0;
   endtask

   // Pulses start in relative cycle 0, acts as every unit answering 'delay'
   // cycles after its op_start, and records starts and done pulses.
   // With stray set, op_done[3] is also pulsed while unit 0 is being waited on.
   task automatic run_prog(input logic [15:0] len, input logic [31:0] iters,
                           input int delay, input bit stray, input int max_cyc);
      int                   pend_cyc;
      logic [NUM_UNITS-1:0] pend_val;
      start_cyc_q.delete();
      start_val_q.delete();
      start_regs_q.delete();
      done_cnt  = 0;
      done_cyc  = -1;
      done_busy = 1'bx;
      busy_c1   = 1'bx;
      pend_cyc  = -1;
      pend_val  = '0;
      @(negedge clk);
      program_length = len;
      num_iterations = iters;
      start          = 1'b1;
      for (int c = 0; c < max_cyc; c++) begin
         if (c > 0) begin
            @(negedge clk);
            start = 1'b0;
         end
         if (c == 1) busy_c1 = busy;
         if (op_start != '0) begin
            start_cyc_q.push_back(c);
            start_val_q.push_back(op_start);
            start_regs_q.push_back(pack_regs());
            pend_cyc = c + delay;
            pend_val = op_start;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc  = c;
               done_busy = busy;
            end
         end
         op_done = (c == pend_cyc) ? pend_val : '0;
         if (stray && pend_val == 4'b0001 && c == pend_cyc - 2) op_done[3] = 1'b1;
         if (done_cyc >= 0 && c >= done_cyc + 5) break;
      end
      op_done = '0;
      start   = 1'b0;
      check("run_done_seen", 128'(done_cyc >= 0), 128'(1));
   endtask

   task automatic check_starts(input string tag);
      check({tag, "_count"}, 128'(start_val_q.size()), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         check({tag, "_onehot"},
               (i < start_val_q.size()) ? 128'(start_val_q[i]) : 128'hx,
               128'(exp_q[i]));
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic       no_activity;
      reset          = 1'b1;
      start          = 1'b0;
      program_length = '0;
      num_iterations = '0;
      instr_we       = 1'b0;
      instr_waddr    = '0;
      instr_wdata    = '0;
      op_done        = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_op_start", 128'(op_start), 128'(0));
      check("rst_pc", 128'(pc), 128'(0));
      check("rst_iteration", 128'(iteration), 128'(0));
      check("rst_illegal", 128'(illegal_count), 128'(0));
      check("rst_regs", pack_regs(), 128'(0));
      check("rst_state", 128'(dbg_state), 128'(IDLE));
      reset = 1'b0;

      // Single opcode-0 instruction, unit answers at T+10
      write_word(0, mk(4'd0, 8'h11));
      run_prog(16'd1, 32'd1, 7, 1'b0, 40);
      exp_q = '{4'b0001};
      check_starts("t1");
      check("t1_start_cycle", 128'(start_cyc_q.size() > 0 ? start_cyc_q[0] : -1), 128'(3));
      check("t1_regs", start_regs_q.size() > 0 ? start_regs_q[0] : 128'hx, mk(4'd0, 8'h11));
      check("t1_busy_c1", 128'(busy_c1), 128'(1));
      check("t1_done_cycle", 128'(done_cyc), 128'(12));
      check("t1_busy_at_done", 128'(done_busy), 128'(0));
      check("t1_iteration", 128'(iteration), 128'(1));
      check("t1_regs_hold", pack_regs(), mk(4'd0, 8'h11));

      // Program [1,2,3], two passes, units answer after 5 cycles
      write_word(0, mk(4'd1, 8'h21));
      write_word(1, mk(4'd2, 8'h22));
      write_word(2, mk(4'd3, 8'h23));
      run_prog(16'd3, 32'd2, 5, 1'b0, 200);
      exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
      check_starts("t2");
      check("t2_gap", 128'(start_cyc_q.size() > 1 ? start_cyc_q[1] - start_cyc_q[0] : -1), 128'(9));
      check("t2_regs_2nd", start_regs_q.size() > 4 ? start_regs_q[4] : 128'hx, mk(4'd2, 8'h22));
      check("t2_iteration", 128'(iteration), 128'(2));
      check("t2_done_count", 128'(done_cnt), 128'(1));

      // Zero length, then zero iterations
      run_prog(16'd0, 32'd5, 5, 1'b0, 20);
      check("t3_len0_starts", 128'(start_val_q.size()), 128'(0));
      check("t3_len0_done_cycle", 128'(done_cyc), 128'(2));
      check("t3_len0_busy_c1", 128'(busy_c1), 128'(1));
      run_prog(16'd3, 32'd0, 5, 1'b0, 20);
      check("t3_it0_starts", 128'(start_val_q.size()), 128'(0));
      check("t3_it0_done_cycle", 128'(done_cyc), 128'(2));
      check("t3_it0_iteration", 128'(iteration), 128'(0));

      // Program [0, illegal 9, 1] with a stray op_done[3]
      write_word(0, mk(4'd0, 8'h31));
      write_word(1, mk(4'd9, 8'h32));
      write_word(2, mk(4'd1, 8'h33));
      run_prog(16'd3, 32'd1, 5, 1'b1, 100);
      exp_q = '{4'b0001, 4'b0010};
      check_starts("t4");
      check("t4_gap", 128'(start_cyc_q.size() > 1 ? start_cyc_q[1] - start_cyc_q[0] : -1), 128'(12));
      check("t4_regs_2nd", start_regs_q.size() > 1 ? start_regs_q[1] : 128'hx, mk(4'd1, 8'h33));
      check("t4_illegal", 128'(illegal_count), 128'(1));
      check("t4_done_count", 128'(done_cnt), 128'(1));

      // Reset while waiting on a unit
      write_word(0, mk(4'd2, 8'h41));
      @(negedge clk);
      program_length = 16'd1;
      num_iterations = 32'd1;
      start          = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("t5_op_start", 128'(op_start), 128'(4'b0100));
      repeat (2) @(negedge clk);
      check("t5_state_wait", 128'(dbg_state), 128'(WAIT_DONE));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5_busy", 128'(busy), 128'(0));
      check("t5_done", 128'(done), 128'(0));
      check("t5_pc", 128'(pc), 128'(0));
      check("t5_iteration", 128'(iteration), 128'(0));
      check("t5_regs", pack_regs(), 128'(0));
      check("t5_state", 128'(dbg_state), 128'(IDLE));
      @(negedge clk);
      op_done     = 4'b0100;
      no_activity = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         op_done = '0;
         if (op_start != '0 || busy || done) no_activity = 1'b0;
      end
      check("t5_after_reset_idle", 128'(no_activity), 128'(1));
      run_prog(16'd1, 32'd1, 5, 1'b0, 40);
      exp_q = '{4'b0100};
      check_starts("t5_rerun");
      check("t5_rerun_done_count", 128'(done_cnt), 128'(1));

      // Program length beyond RAM depth: index 256/257 reread addresses 0/1
      write_word(0, mk(4'd0, 8'h51));
      write_word(1, mk(4'd1, 8'h52));
      for (int a = 2; a < 256; a++) write_word(a, mk(4'hF, 8'(a)));
      run_prog(16'd258, 32'd1, 3, 1'b0, 3000);
      exp_q = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
      check_starts("t6");
      check("t6_illegal", 128'(illegal_count), 128'(254));
      check("t6_iteration", 128'(iteration), 128'(1));

`ifdef GLM_DISPATCH_TIMEOUT_EN
      // Unit never answers: watchdog ends the run 100 cycles after WAIT_DONE entry
      run_prog(16'd1, 32'd1, 100000, 1'b0, 200);
      check("t7_done_cycle", 128'(done_cyc), 128'(103));
      check("t7_timeout_err", 128'(timeout_err), 128'(1));
      check("t7_starts", 128'(start_val_q.size()), 128'(1));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
